instruction_fetch_unit: RTL and testbench

//   Fetch stage of the RV32I core. Holds the program counter and drives the

---
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage of the RV32I core. The program counter addresses a
//   combinational instruction ROM. Each returned word is queued with its PC
//   in a small FIFO. The FIFO feeds decode over a valid/ready handshake. A
//   redirect from execute flushes the queue and reloads the PC.
//
// Parameters
//   RESET_PC    PC loaded on reset (word aligned)
//   FIFO_DEPTH  fetch queue entries (power of 2, >= 2)
//
// Ports
//   clk             core clock, rising edge
//   reset           synchronous active-high reset
//   rom_address     byte address to instruction ROM (the pc register)
//   rom_data        instruction word from ROM, same cycle
//   redirect_valid  execute requests a PC change
//   redirect_pc     redirect target byte address (low two bits dropped)
//   inst_valid      queue head holds a valid instruction
//   inst_data       instruction word at queue head
//   inst_pc         PC of instruction at queue head
//   inst_ready      decode accepts the head this cycle
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc;
  logic [31:0]      mem_pc   [FIFO_DEPTH];
  logic [31:0]      mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic full;
  logic pop;
  logic push;
  logic unused_redirect_low;

  // The misaligned low bits of a redirect target are dropped on purpose.
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign rom_address = pc;

  // The head is read straight out of the queue storage. Nothing drives it
  // combinationally from inputs. The head entry is never overwritten while
  // valid because a full queue only accepts a push alongside a pop.
  assign inst_valid = (count != '0);
  assign inst_data  = mem_data[head];
  assign inst_pc    = mem_pc[head];

  // A pop in a full queue frees a slot in the same cycle, so fetch can keep
  // streaming at one instruction per cycle. A redirect suppresses the push,
  // which discards the ROM word currently on the bus.
  always_comb begin
    full = (count == CNT_W'(FIFO_DEPTH));
    pop  = inst_valid & inst_ready;
    push = ~redirect_valid & (~full | pop);
  end

  // PC and queue state. Reset wins over a redirect, and a redirect wins over
  // a push. Storage is cleared on reset so that the head reads back as zero
  // and no stale entry survives. A redirect only clears the pointers and the
  // count, because the head contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_pc[tail]   <= pc;
        mem_data[tail] <= rom_data;
        tail           <= tail + PTR_W'(1);
        pc             <= pc + 32'd4;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Self-checking bench for instruction_fetch_unit. A reference model tracks
//   the PC and keeps a scoreboard queue of expected {pc, word} entries. Each
//   handshake pop is compared against the front of that queue. Directed steps
//   also check the fixed values that the fetch scenarios call for.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic        m_pop;
  logic        m_push;

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM contents.
  function automatic logic [31:0] romLookup(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: romLookup = 32'h00a0_0093;
      32'h0000_0004: romLookup = 32'h0140_0113;
      32'h0000_0008: romLookup = 32'h01e0_0193;
      32'h0000_000C: romLookup = 32'h4010_2023;
      32'h0000_0010: romLookup = 32'h0000_0013;
      32'h0000_0014: romLookup = 32'h4020_2223;
      32'h0000_0018: romLookup = 32'h4040_2283;
      32'hFFFF_FFFC: romLookup = 32'h0000_006F;
      default:       romLookup = {addr[15:0], ~addr[15:0]};
    endcase
  endfunction

  // Combinational ROM.
  always_comb rom_data = romLookup(rom_address);

  // One comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge,
  // and compare the DUT against it.
  task automatic applyStimulus(input logic rst, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    m_pop  = !rst && (exp_q.size() != 0) && rdy;
    m_push = !rv && ((exp_q.size() < DEPTH) || m_pop);
    if (m_pop) begin
      checkOutput("pop_pc", inst_pc, exp_q[0][63:32]);
      checkOutput("pop_data", inst_data, exp_q[0][31:0]);
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (rv) begin
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back({model_pc, romLookup(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
    #1;
    checkOutput("rom_address", rom_address, model_pc);
    checkOutput("inst_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      checkOutput("head_pc", inst_pc, exp_q[0][63:32]);
      checkOutput("head_data", inst_data, exp_q[0][31:0]);
    end
  endtask

  // Global time bound.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    model_pc       = RESET_PC;

    // Reset state
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rst_pc", inst_pc, 32'd0);
    checkOutput("rst_data", inst_data, 32'd0);
    checkOutput("rst_addr", rom_address, RESET_PC);

    // Streaming with ready high
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_pc0", inst_pc, 32'h0);
    checkOutput("s1_d0", inst_data, 32'h00a00093);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_pc4", inst_pc, 32'h4);
    checkOutput("s1_d4", inst_data, 32'h01400113);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_pc8", inst_pc, 32'h8);
    checkOutput("s1_d8", inst_data, 32'h01e00193);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_pcC", inst_pc, 32'hC);
    checkOutput("s1_dC", inst_data, 32'h40102023);

    // Stall until the queue is full
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s2_addr", rom_address, 32'h8);
    checkOutput("s2_head_pc", inst_pc, 32'h0);
    checkOutput("s2_head_d", inst_data, 32'h00a00093);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s2_pc4", inst_pc, 32'h4);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s2_pc8", inst_pc, 32'h8);

    // Redirect while full
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'h14, 0);
    checkOutput("s3_bubble", {31'd0, inst_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s3_valid", {31'd0, inst_valid}, 32'd1);
    checkOutput("s3_pc", inst_pc, 32'h14);
    checkOutput("s3_data", inst_data, 32'h40202223);

    // Misaligned redirect target
    applyStimulus(0, 1, 32'h1B, 1);
    checkOutput("s4_addr", rom_address, 32'h18);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s4_data", inst_data, 32'h40402283);

    // PC wrap at the top of the address space
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
    checkOutput("s5_addr_top", rom_address, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s5_addr_wrap", rom_address, 32'h0);
    checkOutput("s5_pc_top", inst_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s5_pc_zero", inst_pc, 32'h0);

    // Back-to-back redirects
    applyStimulus(0, 1, 32'h40, 1);
    applyStimulus(0, 1, 32'h80, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("b2b_pc", inst_pc, 32'h80);

    // Reset while full and stalled
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("s6_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("s6_addr", rom_address, RESET_PC);
    checkOutput("s6_pc", inst_pc, 32'd0);
    checkOutput("s6_data", inst_data, 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s6_restart0", inst_pc, 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s6_restart4", inst_pc, 32'h4);

    // Reset has priority over a redirect
    applyStimulus(1, 1, 32'h40, 1);
    checkOutput("rst_prio_addr", rom_address, RESET_PC);

    // Random ready and redirect traffic against the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, ($urandom_range(0, 7) == 0),
                    32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
